pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Keeps its own shadow of the destination tags in flight in EXE and MEM, so ID no longer needs tags fed back from the later stages.
- Combines data-hazard detection, memory wait and branch flush into one prioritised set of freeze/bubble/flush controls.
- Keeps saturating performance counters for hazard stalls and memory-wait cycles.

Parameters:
CNT_W, 16, width of each performance counter
NREG_W, 4, register index width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_src1  in  NREG_W  first source register
id_src2  in  NREG_W  second source register
id_two_src  in  1  id_src2 is a real operand
id_wb_en  in  1  ID instruction writes the register file
id_dest  in  NREG_W  ID destination register
id_mem_read  in  1  ID instruction is a load
fwd_en  in  1  forwarding unit enabled
branch_taken  in  1  EXE resolved a taken branch this cycle
mem_ready  in  1  memory stage done; 0 = wait
perf_clr  in  1  synchronous clear of both counters
pc_freeze  out  1  hold PC
ifid_freeze  out  1  hold IF/ID register
ifid_flush  out  1  clear IF/ID register
idexe_bubble  out  1  load a NOP into ID/EXE
pipe_freeze  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers
hazard_detected  out  1  raw data-hazard indication
hazard_stall_cnt  out  CNT_W  cycles spent in hazard stalls
mem_wait_cnt  out  CNT_W  cycles spent in memory wait

Behaviour:
- Shadow slots EXE and MEM each hold {valid, wb_en, mem_read, dest}. Reset clears valid in both slots; counters reset to 0.
- All control outputs are combinational from slot state and inputs. While rst=1, every control output is forced to 0.
- match(S) = S.valid & S.wb_en & id_valid & (id_src1==S.dest | (id_two_src & id_src2==S.dest)).
- fwd_en=0: hazard_detected = match(EXE) | match(MEM).
- fwd_en=1: hazard_detected = match(EXE) & EXE.mem_read (load-use only).
- Priority each cycle, highest first; exactly one case applies.
  1. WAIT (mem_ready=0):
     - pc_freeze = ifid_freeze = pipe_freeze = 1; all other controls 0.
     - Both slots hold.
     - branch_taken is ignored and must be re-presented once mem_ready rises, since EXE is frozen.
     - mem_wait_cnt increments.
  2. FLUSH (branch_taken=1):
     - ifid_flush = idexe_bubble = 1; pc_freeze = 0.
     - EXE slot <= invalid; MEM slot <= old EXE.
     - Any hazard is ignored.
  3. STALL (hazard_detected=1):
     - pc_freeze = ifid_freeze = idexe_bubble = 1.
     - EXE slot <= invalid; MEM slot <= old EXE.
     - hazard_stall_cnt increments.
  4. RUN:
     - All controls 0 (hazard_detected still reflects the raw computation).
     - EXE slot <= {id_valid, id_wb_en, id_mem_read, id_dest}; MEM slot <= old EXE.
- Slot contents leaving MEM are discarded. WB writes in the first half-cycle, so no WB slot is tracked.
- Counters saturate at all-ones with no wrap.
- perf_clr has priority over an increment in the same cycle; counters read 0 on the next edge.
- perf_clr does not affect the slots.
- hazard_detected is output even during WAIT, but takes no action there.
- Reset asserted mid-stall: the next cycle starts in RUN with empty slots and zero counters.

Test Plan:
- fwd_en=0: issue ADD R3 (wb_en=1), then SUB with src1=R3 -> hazard_detected=1 and bubble for exactly 2 cycles; hazard_stall_cnt=2; SUB enters EXE on cycle 3.
- fwd_en=1: same sequence with a non-load ADD -> no stall. Then LDR R5 followed by an instruction with src2=R5, two_src=1 -> exactly 1 bubble cycle.
- Case with two_src=0 and src2 matching EXE dest -> hazard_detected=0.
- mem_ready=0 for 4 cycles with a pending hazard -> pc_freeze=ifid_freeze=pipe_freeze=1 and idexe_bubble=0 throughout; slots unchanged; mem_wait_cnt=4; hazard_stall_cnt unchanged.
- branch_taken=1 together with hazard_detected=1 -> ifid_flush=1, idexe_bubble=1, pc_freeze=0; EXE slot invalid on the next cycle.
- Force hazard_stall_cnt to 0xFFFE, stall 3 cycles -> counter reads 0xFFFF. Assert perf_clr together with a stall -> counter reads 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: tracks destination tags in EXE/MEM,
// resolves wait/flush/stall/run priority and keeps saturating stall counters.
module pipeline_stall_controller #(
   parameter int CNT_W  = 16,
   parameter int NREG_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid_i,
   input  logic [NREG_W-1:0] id_src1_i,
   input  logic [NREG_W-1:0] id_src2_i,
   input  logic              id_two_src_i,
   input  logic              id_wb_en_i,
   input  logic [NREG_W-1:0] id_dest_i,
   input  logic              id_mem_read_i,
   input  logic              fwd_en_i,
   input  logic              branch_taken_i,
   input  logic              mem_ready_i,
   input  logic              perf_clr_i,
   output logic              pc_freeze_o,
   output logic              ifid_freeze_o,
   output logic              ifid_flush_o,
   output logic              idexe_bubble_o,
   output logic              pipe_freeze_o,
   output logic              hazard_detected_o,
   output logic [CNT_W-1:0]  hazard_stall_cnt_o,
   output logic [CNT_W-1:0]  mem_wait_cnt_o
);

   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_STALL = 2'd1,
      MODE_FLUSH = 2'd2,
      MODE_WAIT  = 2'd3
   } mode_e;

   logic              exe_valid_q, exe_valid_d;
   logic              exe_wb_q, exe_wb_d;
   logic              exe_mrd_q, exe_mrd_d;
   logic [NREG_W-1:0] exe_dest_q, exe_dest_d;
   logic              mem_valid_q, mem_valid_d;
   logic              mem_wb_q, mem_wb_d;
   logic [NREG_W-1:0] mem_dest_q, mem_dest_d;
   logic [CNT_W-1:0]  hstall_q, hstall_d;
   logic [CNT_W-1:0]  mwait_q, mwait_d;

   logic  match_exe_s, match_mem_s, hazard_s;
   mode_e mode_s;

   // Source operands against each shadow slot; src2 only counts when it is a real operand.
   always_comb begin
      match_exe_s = exe_valid_q & exe_wb_q & id_valid_i &
                    ((id_src1_i == exe_dest_q) | (id_two_src_i & (id_src2_i == exe_dest_q)));
      match_mem_s = mem_valid_q & mem_wb_q & id_valid_i &
                    ((id_src1_i == mem_dest_q) | (id_two_src_i & (id_src2_i == mem_dest_q)));
      if (fwd_en_i) begin
         hazard_s = match_exe_s & exe_mrd_q;
      end else begin
         hazard_s = match_exe_s | match_mem_s;
      end
   end

   // Prioritise memory wait over branch flush over hazard stall.
   always_comb begin
      if (!mem_ready_i) begin
         mode_s = MODE_WAIT;
      end else if (branch_taken_i) begin
         mode_s = MODE_FLUSH;
      end else if (hazard_s) begin
         mode_s = MODE_STALL;
      end else begin
         mode_s = MODE_RUN;
      end
   end

   // Control outputs decoded from the active mode, all held low during reset.
   always_comb begin
      pc_freeze_o       = 1'b0;
      ifid_freeze_o     = 1'b0;
      ifid_flush_o      = 1'b0;
      idexe_bubble_o    = 1'b0;
      pipe_freeze_o     = 1'b0;
      hazard_detected_o = 1'b0;
      if (rst) begin
         hazard_detected_o = 1'b0;
      end else begin
         hazard_detected_o = hazard_s;
         case (mode_s)
            MODE_WAIT: begin
               pc_freeze_o   = 1'b1;
               ifid_freeze_o = 1'b1;
               pipe_freeze_o = 1'b1;
            end
            MODE_FLUSH: begin
               ifid_flush_o   = 1'b1;
               idexe_bubble_o = 1'b1;
            end
            MODE_STALL: begin
               pc_freeze_o    = 1'b1;
               ifid_freeze_o  = 1'b1;
               idexe_bubble_o = 1'b1;
            end
            MODE_RUN:   pc_freeze_o = 1'b0;
            default:    pc_freeze_o = 1'b0;
         endcase
      end
   end

   // Shadow slot advance: frozen in wait, bubble into EXE on flush/stall, ID tag on run.
   always_comb begin
      exe_valid_d = exe_valid_q;
      exe_wb_d    = exe_wb_q;
      exe_mrd_d   = exe_mrd_q;
      exe_dest_d  = exe_dest_q;
      mem_valid_d = exe_valid_q;
      mem_wb_d    = exe_wb_q;
      mem_dest_d  = exe_dest_q;
      case (mode_s)
         MODE_WAIT: begin
            mem_valid_d = mem_valid_q;
            mem_wb_d    = mem_wb_q;
            mem_dest_d  = mem_dest_q;
         end
         MODE_FLUSH, MODE_STALL: begin
            exe_valid_d = 1'b0;
            exe_wb_d    = 1'b0;
            exe_mrd_d   = 1'b0;
            exe_dest_d  = '0;
         end
         MODE_RUN: begin
            exe_valid_d = id_valid_i;
            exe_wb_d    = id_wb_en_i;
            exe_mrd_d   = id_mem_read_i;
            exe_dest_d  = id_dest_i;
         end
         default: begin
            exe_valid_d = 1'b0;
         end
      endcase
   end

   // Saturating counters; a clear request beats an increment in the same cycle.
   always_comb begin
      hstall_d = hstall_q;
      mwait_d  = mwait_q;
      if (perf_clr_i) begin
         hstall_d = '0;
         mwait_d  = '0;
      end else begin
         if ((mode_s == MODE_STALL) && (hstall_q != {CNT_W{1'b1}})) begin
            hstall_d = hstall_q + CNT_W'(1);
         end else begin
            hstall_d = hstall_q;
         end
         if ((mode_s == MODE_WAIT) && (mwait_q != {CNT_W{1'b1}})) begin
            mwait_d = mwait_q + CNT_W'(1);
         end else begin
            mwait_d = mwait_q;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         exe_valid_q <= 1'b0;
         exe_wb_q    <= 1'b0;
         exe_mrd_q   <= 1'b0;
         exe_dest_q  <= '0;
         mem_valid_q <= 1'b0;
         mem_wb_q    <= 1'b0;
         mem_dest_q  <= '0;
         hstall_q    <= '0;
         mwait_q     <= '0;
      end else begin
         exe_valid_q <= exe_valid_d;
         exe_wb_q    <= exe_wb_d;
         exe_mrd_q   <= exe_mrd_d;
         exe_dest_q  <= exe_dest_d;
         mem_valid_q <= mem_valid_d;
         mem_wb_q    <= mem_wb_d;
         mem_dest_q  <= mem_dest_d;
         hstall_q    <= hstall_d;
         mwait_q     <= mwait_d;
      end
   end

   assign hazard_stall_cnt_o = hstall_q;
   assign mem_wait_cnt_o     = mwait_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; a second instance with 2-bit counters
// exercises saturation in a handful of cycles.
module tb_pipeline_stall_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_two_src, id_wb_en, id_mem_read;
   logic [3:0] id_src1, id_src2, id_dest;
   logic       fwd_en, branch_taken, mem_ready, perf_clr;
   logic       pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, pipe_freeze, hazard_detected;
   logic [15:0] hstall_cnt, mwait_cnt;
   logic       s_pc, s_ifid, s_flush, s_bub, s_pipe, s_haz;
   logic [1:0] s_hstall, s_mwait;
   logic [5:0] ctrl;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   assign ctrl = {pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, pipe_freeze, hazard_detected};

   always #5 clk = ~clk;

   pipeline_stall_controller #(.CNT_W(16), .NREG_W(4)) u_dut (
      .clk(clk), .rst(rst),
      .id_valid_i(id_valid), .id_src1_i(id_src1), .id_src2_i(id_src2),
      .id_two_src_i(id_two_src), .id_wb_en_i(id_wb_en), .id_dest_i(id_dest),
      .id_mem_read_i(id_mem_read), .fwd_en_i(fwd_en), .branch_taken_i(branch_taken),
      .mem_ready_i(mem_ready), .perf_clr_i(perf_clr),
      .pc_freeze_o(pc_freeze), .ifid_freeze_o(ifid_freeze), .ifid_flush_o(ifid_flush),
      .idexe_bubble_o(idexe_bubble), .pipe_freeze_o(pipe_freeze),
      .hazard_detected_o(hazard_detected),
      .hazard_stall_cnt_o(hstall_cnt), .mem_wait_cnt_o(mwait_cnt)
   );

   pipeline_stall_controller #(.CNT_W(2), .NREG_W(4)) u_sat (
      .clk(clk), .rst(rst),
      .id_valid_i(id_valid), .id_src1_i(id_src1), .id_src2_i(id_src2),
      .id_two_src_i(id_two_src), .id_wb_en_i(id_wb_en), .id_dest_i(id_dest),
      .id_mem_read_i(id_mem_read), .fwd_en_i(fwd_en), .branch_taken_i(branch_taken),
      .mem_ready_i(mem_ready), .perf_clr_i(perf_clr),
      .pc_freeze_o(s_pc), .ifid_freeze_o(s_ifid), .ifid_flush_o(s_flush),
      .idexe_bubble_o(s_bub), .pipe_freeze_o(s_pipe),
      .hazard_detected_o(s_haz),
      .hazard_stall_cnt_o(s_hstall), .mem_wait_cnt_o(s_mwait)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                         input logic two, input logic wb, input logic [3:0] d, input logic mr);
      id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
      id_wb_en = wb; id_dest = d; id_mem_read = mr;
   endtask

   task automatic idle(input int n);
      set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      branch_taken = 1'b0; mem_ready = 1'b1; perf_clr = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_id(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1);
      mem_ready = 1'b0; branch_taken = 1'b1; fwd_en = 1'b0; perf_clr = 1'b0;
      #3;
      total_cnt++;
      if (ctrl !== 6'b000000) $display("FAIL reset_ctrl got=%b exp=000000", ctrl); else pass_cnt++;
      step(); step();
      total_cnt++;
      if (mwait_cnt !== 16'd0 || hstall_cnt !== 16'd0)
         $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hstall_cnt, mwait_cnt);
      else pass_cnt++;
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_hazard_nofwd();
      do_reset(); fwd_en = 1'b0;
      set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0);
      #3; total_cnt++;
      if (ctrl !== 6'b000000) $display("FAIL nofwd_add got=%b exp=000000", ctrl); else pass_cnt++;
      step();
      set_id(1'b1, 4'd3, 4'd4, 1'b1, 1'b1, 4'd6, 1'b0);
      #3; total_cnt++;
      if (ctrl !== 6'b110101) $display("FAIL nofwd_stall1 got=%b exp=110101", ctrl); else pass_cnt++;
      step();
      #3; total_cnt++;
      if (ctrl !== 6'b110101) $display("FAIL nofwd_stall2 got=%b exp=110101", ctrl); else pass_cnt++;
      step();
      #3; total_cnt++;
      if (ctrl !== 6'b000000) $display("FAIL nofwd_release got=%b exp=000000", ctrl); else pass_cnt++;
      total_cnt++;
      if (hstall_cnt !== 16'd2) $display("FAIL nofwd_cnt got=%0d exp=2", hstall_cnt); else pass_cnt++;
      step();
      set_id(1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0);
      #3; total_cnt++;
      if (ctrl !== 6'b110101) $display("FAIL nofwd_sub_in_exe got=%b exp=110101", ctrl); else pass_cnt++;
      idle(2);
   endtask

   task automatic test_fwd();
      do_reset(); fwd_en = 1'b1;
      set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0);
      step();
      set_id(1'b1, 4'd3, 4'd4, 1'b1, 1'b1, 4'd6, 1'b0);
      #3; total_cnt++;
      if (ctrl !== 6'b000000) $display("FAIL fwd_alu_nostall got=%b exp=000000", ctrl); else pass_cnt++;
      step();
      set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1);
      step();
      set_id(1'b1, 4'd1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
      #3; total_cnt++;
      if (ctrl !== 6'b110101) $display("FAIL fwd_loaduse got=%b exp=110101", ctrl); else pass_cnt++;
      step();
      #3; total_cnt++;
      if (ctrl !== 6'b000000) $display("FAIL fwd_one_bubble got=%b exp=000000", ctrl); else pass_cnt++;
      total_cnt++;
      if (hstall_cnt !== 16'd1) $display("FAIL fwd_cnt got=%0d exp=1", hstall_cnt); else pass_cnt++;
      idle(2);
   endtask

   task automatic test_two_src();
      do_reset(); fwd_en = 1'b0;
      set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 1'b0);
      step();
      set_id(1'b1, 4'd1, 4'd7, 1'b0, 1'b1, 4'd2, 1'b0);
      #3; total_cnt++;
      if (ctrl !== 6'b000000) $display("FAIL two_src_off got=%b exp=000000", ctrl); else pass_cnt++;
      id_two_src = 1'b1;
      #1; total_cnt++;
      if (ctrl !== 6'b110101) $display("FAIL two_src_on got=%b exp=110101", ctrl); else pass_cnt++;
      idle(3);
   endtask

   task automatic test_mem_wait();
      do_reset(); fwd_en = 1'b1;
      set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
      step();
      set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         branch_taken = (i == 1);
         #3; total_cnt++;
         if (ctrl !== 6'b110011) $display("FAIL wait_cyc%0d got=%b exp=110011", i, ctrl); else pass_cnt++;
         step();
      end
      mem_ready = 1'b1; branch_taken = 1'b0;
      #3; total_cnt++;
      if (ctrl !== 6'b110101) $display("FAIL wait_slots_held got=%b exp=110101", ctrl); else pass_cnt++;
      total_cnt++;
      if (mwait_cnt !== 16'd4 || hstall_cnt !== 16'd0)
         $display("FAIL wait_cnts got=%0d/%0d exp=4/0", mwait_cnt, hstall_cnt);
      else pass_cnt++;
      idle(3);
   endtask

   task automatic test_flush();
      do_reset(); fwd_en = 1'b1;
      set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
      step();
      set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
      branch_taken = 1'b1;
      #3; total_cnt++;
      if (ctrl !== 6'b001101) $display("FAIL flush_ctrl got=%b exp=001101", ctrl); else pass_cnt++;
      step();
      branch_taken = 1'b0;
      #3; total_cnt++;
      if (ctrl !== 6'b000000) $display("FAIL flush_exe_empty got=%b exp=000000", ctrl); else pass_cnt++;
      fwd_en = 1'b0;
      #1; total_cnt++;
      if (ctrl !== 6'b110101) $display("FAIL flush_mem_tag got=%b exp=110101", ctrl); else pass_cnt++;
      total_cnt++;
      if (hstall_cnt !== 16'd0) $display("FAIL flush_nocnt got=%0d exp=0", hstall_cnt); else pass_cnt++;
      idle(3);
   endtask

   task automatic test_saturate_clear();
      do_reset(); fwd_en = 1'b0;
      set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0);
      step();
      set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
      step(); step(); step();
      total_cnt++;
      if (s_hstall !== 2'd2) $display("FAIL sat_pre got=%0d exp=2", s_hstall); else pass_cnt++;
      set_id(1'b1, 4'd6, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0);
      step(); step();
      #3; total_cnt++;
      if (s_hstall !== 2'd3 || hstall_cnt !== 16'd4)
         $display("FAIL sat_hold got=%0d/%0d exp=3/4", s_hstall, hstall_cnt);
      else pass_cnt++;
      step();
      set_id(1'b1, 4'd8, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      perf_clr = 1'b1;
      #3; total_cnt++;
      if (ctrl !== 6'b110101) $display("FAIL clr_stall_ctrl got=%b exp=110101", ctrl); else pass_cnt++;
      step();
      perf_clr = 1'b0;
      #3; total_cnt++;
      if (s_hstall !== 2'd0 || hstall_cnt !== 16'd0)
         $display("FAIL clr_prio got=%0d/%0d exp=0/0", s_hstall, hstall_cnt);
      else pass_cnt++;
      step();
      #3; total_cnt++;
      if (hstall_cnt !== 16'd1) $display("FAIL clr_recount got=%0d exp=1", hstall_cnt); else pass_cnt++;
      idle(3);
   endtask

   task automatic test_reset_mid_stall();
      do_reset(); fwd_en = 1'b0;
      set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0);
      step();
      set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
      step();
      rst = 1'b1;
      #3; total_cnt++;
      if (ctrl !== 6'b000000) $display("FAIL rst_mid_ctrl got=%b exp=000000", ctrl); else pass_cnt++;
      step();
      rst = 1'b0;
      #3; total_cnt++;
      if (ctrl !== 6'b000000 || hstall_cnt !== 16'd0)
         $display("FAIL rst_mid_after got=%b/%0d exp=000000/0", ctrl, hstall_cnt);
      else pass_cnt++;
      idle(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; fwd_en = 1'b0;
      set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      branch_taken = 1'b0; mem_ready = 1'b1; perf_clr = 1'b0;
      step();
      test_reset();
      test_hazard_nofwd();
      test_fwd();
      test_two_src();
      test_mem_wait();
      test_flush();
      test_saturate_clear();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
